// File: rtl/spi_flash_rd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_rd_seq
//  Description : Sequencer for SPI NOR flash reads. Accepts a read request
//                (24-bit address, length-1) and walks the byte shift-engine
//                through command, address, optional dummy and data bytes.
//                Each received data byte is returned on a ready/valid channel.
//                Response back-pressure stalls the SPI transfer. After the
//                last byte, chip select is held high for CS_IDLE cycles.
//                Optional feature macro: SPI_FLASH_FAST_READ_EN
//                  defined   : FAST READ (0x0B) with one dummy byte
//                  undefined : READ (0x03) with no dummy byte
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_rd_seq #(
    parameter int CS_IDLE = 4              // nss_o high cycles, 1..15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    // read-request channel
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [23:0] req_addr_i,
    input  logic [7:0]  req_len_i,
    // read-data channel
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [7:0]  rsp_data_o,
    output logic        rsp_last_o,
    // byte shift-engine handshake
    output logic        eng_start_o,
    output logic [7:0]  eng_tx_o,
    input  logic        eng_done_i,
    input  logic [7:0]  eng_rx_i,
    // flash chip select, active low
    output logic        nss_o
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [3:0] c_st_idle  = 4'd0;
    localparam logic [3:0] c_st_cmd   = 4'd1;
    localparam logic [3:0] c_st_addr2 = 4'd2;
    localparam logic [3:0] c_st_addr1 = 4'd3;
    localparam logic [3:0] c_st_addr0 = 4'd4;
    localparam logic [3:0] c_st_dummy = 4'd5;
    localparam logic [3:0] c_st_data  = 4'd6;
    localparam logic [3:0] c_st_rsp   = 4'd7;
    localparam logic [3:0] c_st_cshi  = 4'd8;

`ifdef SPI_FLASH_FAST_READ_EN
    // FAST READ: one dummy byte between the address and the data phase
    localparam logic [7:0] c_cmd_byte       = 8'h0B;
    localparam logic [3:0] c_st_after_addr0 = c_st_dummy;
`else
    // Plain READ: data follows the address directly
    localparam logic [7:0] c_cmd_byte       = 8'h03;
    localparam logic [3:0] c_st_after_addr0 = c_st_data;
`endif

    // Last count value of the chip-select high phase
    localparam logic [3:0] c_cs_last = 4'(CS_IDLE - 1);

    // ------------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------------
    logic [3:0]  r_state;
    logic [3:0]  w_state_nxt;
    logic        r_start;          // high in the first cycle of a byte state
    logic [23:0] r_addr;
    logic [7:0]  r_len;            // requested byte count minus one
    logic [7:0]  r_cnt;            // index of the data byte in flight
    logic [7:0]  r_rsp_data;
    logic        r_rsp_last;
    logic [3:0]  r_cs_cnt;

    logic        w_byte_state;     // current state drives an engine byte
    logic        w_eng_adv;        // engine finished the byte we started
    logic        w_req_fire;
    logic        w_rsp_fire;
    logic        w_start_nxt;

    // True for states that push one byte through the shift engine
    function automatic logic is_byte_state(input logic [3:0] st);
        case (st)
            c_st_cmd, c_st_addr2, c_st_addr1,
            c_st_addr0, c_st_dummy, c_st_data: is_byte_state = 1'b1;
            default:                           is_byte_state = 1'b0;
        endcase
    endfunction

    // Handshake qualifiers; eng_done_i only counts once the start pulse is over
    always_comb begin
        w_byte_state = is_byte_state(r_state);
        w_eng_adv    = w_byte_state && !r_start && eng_done_i;
        w_req_fire   = req_valid_i && req_ready_o;
        w_rsp_fire   = (r_state == c_st_rsp) && rsp_ready_i;
        // Every byte state is entered from a different state, so a state
        // change into a byte state marks exactly one start pulse.
        w_start_nxt  = is_byte_state(w_state_nxt) && (w_state_nxt != r_state);
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    // State and start-pulse registers; reset aborts any transfer at once
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
            r_start <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_start <= w_start_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    // Sequence: CMD, ADDR2..0, optional DUMMY, then DATA/RSP per byte, CSHI
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_req_fire) begin
                    w_state_nxt = c_st_cmd;
                end
            end
            c_st_cmd: begin
                if (w_eng_adv) begin
                    w_state_nxt = c_st_addr2;
                end
            end
            c_st_addr2: begin
                if (w_eng_adv) begin
                    w_state_nxt = c_st_addr1;
                end
            end
            c_st_addr1: begin
                if (w_eng_adv) begin
                    w_state_nxt = c_st_addr0;
                end
            end
            c_st_addr0: begin
                if (w_eng_adv) begin
                    w_state_nxt = c_st_after_addr0;
                end
            end
            c_st_dummy: begin
                if (w_eng_adv) begin
                    w_state_nxt = c_st_data;
                end
            end
            c_st_data: begin
                if (w_eng_adv) begin
                    w_state_nxt = c_st_rsp;
                end
            end
            c_st_rsp: begin
                if (w_rsp_fire) begin
                    w_state_nxt = r_rsp_last ? c_st_cshi : c_st_data;
                end
            end
            c_st_cshi: begin
                if (r_cs_cnt == c_cs_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------------
    // Chip select, request ready, response valid and the byte to shift out
    always_comb begin
        nss_o       = 1'b1;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        eng_tx_o    = 8'h00;
        case (r_state)
            c_st_idle: begin
                // Held off while reset is asserted, up the first cycle after
                req_ready_o = !rst_i;
            end
            c_st_cmd: begin
                nss_o    = 1'b0;
                eng_tx_o = c_cmd_byte;
            end
            c_st_addr2: begin
                nss_o    = 1'b0;
                eng_tx_o = r_addr[23:16];
            end
            c_st_addr1: begin
                nss_o    = 1'b0;
                eng_tx_o = r_addr[15:8];
            end
            c_st_addr0: begin
                nss_o    = 1'b0;
                eng_tx_o = r_addr[7:0];
            end
            c_st_dummy, c_st_data: begin
                nss_o    = 1'b0;
            end
            c_st_rsp: begin
                nss_o       = 1'b0;
                rsp_valid_o = 1'b1;
            end
            default: begin
                nss_o = 1'b1;
            end
        endcase
        eng_start_o = r_start;
        rsp_data_o  = r_rsp_data;
        rsp_last_o  = r_rsp_last;
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Request capture, data-byte counting and response capture
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_addr     <= 24'h00_0000;
            r_len      <= 8'h00;
            r_cnt      <= 8'h00;
            r_rsp_data <= 8'h00;
            r_rsp_last <= 1'b0;
        end else begin
            if (w_req_fire) begin
                // Address is sent once; the flash itself handles wrap-around
                r_addr <= req_addr_i;
                r_len  <= req_len_i;
                r_cnt  <= 8'h00;
            end
            if ((r_state == c_st_data) && w_eng_adv) begin
                r_rsp_data <= eng_rx_i;
                r_rsp_last <= (r_cnt == r_len);
            end
            if (w_rsp_fire) begin
                r_cnt      <= r_cnt + 8'd1;
                r_rsp_last <= 1'b0;
            end
        end
    end

    // Chip-select high timer, running only while in CSHI
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cs_cnt <= 4'd0;
        end else if (r_state == c_st_cshi) begin
            r_cs_cnt <= r_cs_cnt + 4'd1;
        end else begin
            r_cs_cnt <= 4'd0;
        end
    end

endmodule
`default_nettype wire

// File: doc/spi_flash_rd_seq.md
SPI_FLASH_RD_SEQ -- requirements
Module: spi_flash_rd_seq

Interface
REQ-001 SHALL have parameter CS_IDLE, default 4, minimum cycles nss_o held high between transactions (legal range 1..15).
REQ-002 SHALL have the clock port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 SHALL have the reset port rst_i, input, 1 bit: reset that is synchronous and active-high.
REQ-004 SHALL have req_valid_i (in, 1), req_ready_o (out, 1), req_addr_i (in, 24), req_len_i (in, 8, byte count minus 1): read-request channel.
REQ-005 SHALL have rsp_valid_o (out, 1), rsp_ready_i (in, 1), rsp_data_o (out, 8), rsp_last_o (out, 1): read-data channel.
REQ-006 SHALL have eng_start_o (out, 1), eng_tx_o (out, 8), eng_done_i (in, 1), eng_rx_i (in, 8): byte shift-engine handshake.
REQ-007 SHALL have nss_o (out, 1): flash chip select, active low.

Function
REQ-008 SHALL implement states IDLE, CMD, ADDR2, ADDR1, ADDR0, DUMMY, DATA, RSP, CSHI.
REQ-009 SHALL assert req_ready_o only in IDLE; on req_valid_i & req_ready_o, latch addr/len and enter CMD next cycle.
REQ-010 SHALL drive nss_o low in CMD through RSP inclusive; high in IDLE and CSHI.
REQ-011 SHALL, on entry to each byte state (CMD, ADDR2, ADDR1, ADDR0, DUMMY, DATA), pulse eng_start_o for exactly one cycle, with eng_tx_o valid that cycle and held until eng_done_i.
REQ-012 SHALL send eng_tx_o = command byte in CMD, addr[23:16] in ADDR2, addr[15:8] in ADDR1, addr[7:0] in ADDR0, 0x00 in DUMMY and DATA.
REQ-013 SHALL, on eng_done_i in a byte state, advance to the next state the following cycle: CMD->ADDR2->ADDR1->ADDR0->(DUMMY)->DATA.
REQ-014 SHALL, on eng_done_i in DATA, register eng_rx_i into rsp_data_o and enter RSP with rsp_valid_o = 1.
REQ-015 SHALL hold rsp_valid_o, rsp_data_o, rsp_last_o stable until rsp_ready_i; back-pressure stalls the SPI (no start issued in RSP).
REQ-016 SHALL assert rsp_last_o with the byte number req_len_i+1 (req_len_i=0 gives 1 byte, 255 gives 256 bytes).
REQ-017 SHALL, on rsp handshake, go to DATA if bytes remain, else CSHI.
REQ-018 SHALL stay in CSHI for exactly CS_IDLE cycles, then enter IDLE.
REQ-019 SHALL ignore eng_done_i when not waiting on a started byte (IDLE, RSP, CSHI, or start cycle itself).
REQ-020 SHALL not wrap the 24-bit address internally; the flash handles wrap past 0xFFFFFF.
REQ-021 SHALL ignore req_valid_i outside IDLE (no queuing).

Reset
REQ-022 SHALL, with rst_i high at a clock edge, force IDLE, nss_o=1, eng_start_o=0, eng_tx_o=0x00, rsp_valid_o=0, rsp_data_o=0x00, rsp_last_o=0, req_ready_o=0 during reset, counters zero.
REQ-023 SHALL, on reset mid-transaction, abort immediately (nss_o high next edge) and discard pending data; req_ready_o=1 the first cycle after rst_i deasserts.

Configuration
REQ-024 SHALL use macro SPI_FLASH_FAST_READ_EN: when defined, command 0x0B and one DUMMY byte after ADDR0; when undefined, command 0x03 and DUMMY skipped (ADDR0->DATA).

Verification
REQ-025 Reset, then req addr=0x123456 len=0 -> eng_tx_o sequence 0x03,0x12,0x34,0x56,0x00; one rsp byte with rsp_last_o=1; nss_o high 4 cycles before req_ready_o=1.
REQ-026 Engine done 1 cycle after each start, len=3, rsp_ready_i held 1 -> 4 rsp bytes equal to eng_rx_i values, rsp_last_o only on 4th, nss_o continuously low across them.
REQ-027 rsp_ready_i held low 10 cycles on byte 2 -> rsp_valid_o/rsp_data_o stable, eng_start_o stays 0 for those cycles.
REQ-028 rst_i pulsed during ADDR1 -> nss_o=1 and rsp_valid_o=0 the next edge; new request afterwards completes normally.
REQ-029 With SPI_FLASH_FAST_READ_EN defined, addr=0x000000 len=255 -> tx 0x0B,0x00,0x00,0x00,0x00(dummy), then 256 data bytes, rsp_last_o on the 256th.
REQ-030 Spurious eng_done_i in IDLE and CSHI, req_valid_i asserted in DATA -> no state change, no extra start, request not accepted until IDLE.
